// File: rtl/illm_row_gather_if.sv
// Serial-in / 8-lane parallel-out token bus for illm_row_gather.
// Lane N of a_d/a_v/a_e/a_b is index N of the packed arrays (lane 0 = first token).
interface illm_row_gather_if;
   logic signed [15:0] din_d;
   logic               din_v;
   logic               din_e;
   logic               din_b;
   logic [7:0][15:0]   a_d;
   logic [7:0]         a_v;
   logic [7:0]         a_e;
   logic [7:0]         a_b;

   modport master (output din_d, din_v, din_e, a_b,
                   input  din_b, a_d, a_v, a_e);
   modport slave  (input  din_d, din_v, din_e, a_b,
                   output din_b, a_d, a_v, a_e);
endinterface

// File: rtl/illm_row_gather.sv
// Gathers 8 serial signed coefficients into one parallel row for the reorder stage.
// Define ILLM_ROW_GATHER_PAD_EN to zero-pad (rather than drop) a row cut short by end-of-stream.
module illm_row_gather (
   input  logic              clock,
   input  logic              reset,
   illm_row_gather_if.slave  bus,
   output logic              row_err
);
   typedef enum logic [1:0] {
      GATHER  = 2'd0,
      EMIT    = 2'd1,
      EOS_OUT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_idx, w_idx_nxt;
   logic [7:0][15:0] r_slot, w_slot_nxt;
   logic [7:0][15:0] r_a_d, w_a_d_nxt;
   logic             r_a_v, w_a_v_nxt;
   logic             r_a_e, w_a_e_nxt;
   logic             r_row_err, w_row_err_nxt;
   logic             r_eos_pend, w_eos_pend_nxt;
   logic             w_take;
   logic             w_fire;

   // All lanes share one valid/eos register, so no lane can present or fire alone.
   assign bus.din_b = (r_state != GATHER);
   assign bus.a_v   = {8{r_a_v}};
   assign bus.a_e   = {8{r_a_e}};
   assign bus.a_d   = r_a_d;
   assign row_err   = r_row_err;
   assign w_take    = bus.din_v & ~bus.din_b;
   assign w_fire    = r_a_v & ~(|bus.a_b);

   // Next-state and next-register values for the gather/emit sequence.
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_slot_nxt     = r_slot;
      w_a_d_nxt      = r_a_d;
      w_a_v_nxt      = r_a_v;
      w_a_e_nxt      = r_a_e;
      w_row_err_nxt  = r_row_err;
      w_eos_pend_nxt = r_eos_pend;
      case (r_state)
         GATHER: begin
            if (w_take && !bus.din_e) begin
               w_slot_nxt[r_idx] = bus.din_d;
               w_idx_nxt         = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_a_d_nxt   = w_slot_nxt;
                  w_a_v_nxt   = 1'b1;
                  w_a_e_nxt   = 1'b0;
                  w_state_nxt = EMIT;
               end else begin
                  w_state_nxt = GATHER;
               end
            end else if (w_take) begin
               w_idx_nxt = 3'd0;
               if (r_idx == 3'd0) begin
                  w_a_d_nxt   = {8{16'h0000}};
                  w_a_v_nxt   = 1'b1;
                  w_a_e_nxt   = 1'b1;
                  w_state_nxt = EOS_OUT;
               end else begin
                  w_row_err_nxt = 1'b1;
`ifdef ILLM_ROW_GATHER_PAD_EN
                  for (int n = 0; n < 8; n++) begin
                     if (3'(n) >= r_idx) begin
                        w_slot_nxt[3'(n)] = 16'h0000;
                     end else begin
                        w_slot_nxt[3'(n)] = r_slot[3'(n)];
                     end
                  end
                  w_a_d_nxt      = w_slot_nxt;
                  w_a_v_nxt      = 1'b1;
                  w_a_e_nxt      = 1'b0;
                  w_eos_pend_nxt = 1'b1;
                  w_state_nxt    = EMIT;
`else
                  w_slot_nxt  = {8{16'h0000}};
                  w_a_d_nxt   = {8{16'h0000}};
                  w_a_v_nxt   = 1'b1;
                  w_a_e_nxt   = 1'b1;
                  w_state_nxt = EOS_OUT;
`endif
               end
            end else begin
               w_state_nxt = GATHER;
            end
         end
         EMIT: begin
            if (w_fire && r_eos_pend) begin
               // Padded final row has left; the end-of-stream marker follows.
               w_eos_pend_nxt = 1'b0;
               w_a_d_nxt      = {8{16'h0000}};
               w_a_e_nxt      = 1'b1;
               w_state_nxt    = EOS_OUT;
            end else if (w_fire) begin
               w_a_v_nxt   = 1'b0;
               w_state_nxt = GATHER;
            end else begin
               w_state_nxt = EMIT;
            end
         end
         EOS_OUT: begin
            if (w_fire) begin
               w_a_v_nxt   = 1'b0;
               w_a_e_nxt   = 1'b0;
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = EOS_OUT;
            end
         end
         DONE: begin
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = GATHER;
            w_a_v_nxt   = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= GATHER;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Row storage, registered outputs and sticky error flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_idx      <= 3'd0;
         r_slot     <= {8{16'h0000}};
         r_a_d      <= {8{16'h0000}};
         r_a_v      <= 1'b0;
         r_a_e      <= 1'b0;
         r_row_err  <= 1'b0;
         r_eos_pend <= 1'b0;
      end else begin
         r_idx      <= w_idx_nxt;
         r_slot     <= w_slot_nxt;
         r_a_d      <= w_a_d_nxt;
         r_a_v      <= w_a_v_nxt;
         r_a_e      <= w_a_e_nxt;
         r_row_err  <= w_row_err_nxt;
         r_eos_pend <= w_eos_pend_nxt;
      end
   end
endmodule

// File: tb/tb_illm_row_gather.sv
// Bench for illm_row_gather: directed handshake/latency/reset cases plus randomized
// episodes scored against a token-list row model (honours ILLM_ROW_GATHER_PAD_EN).
module tb_illm_row_gather;
   typedef struct packed {
      logic [15:0] d;
      logic        e;
   } tok_t;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   logic row_err;
   logic bp_en = 1'b0;
   logic [7:0] bp_rand = 8'h00;
   logic [7:0] ab_force = 8'h00;

   int n_checks = 0;
   int n_errors = 0;
   int gbase = 0;

   tok_t         sent[$];
   logic [135:0] got[$];
   logic [135:0] exp_rows[$];
   logic         exp_err;
   logic         exp_eos;

   illm_row_gather_if bus ();

   illm_row_gather dut (
      .clock   (clock),
      .reset   (rst_n),
      .bus     (bus),
      .row_err (row_err)
   );

   always #5 clock = ~clock;

   assign bus.a_b = bp_en ? bp_rand : ab_force;

   // Random downstream stalls, occasionally on a subset of lanes.
   always @(posedge clock) begin
      #1;
      if ($urandom_range(0, 9) < 3) bp_rand = 8'($urandom_range(1, 255));
      else bp_rand = 8'h00;
   end

   // Row monitor: a row leaves when every lane is valid and none is stalled.
   always @(negedge clock) begin
      if (rst_n && (&bus.a_v) && !(|bus.a_b)) got.push_back({bus.a_e, bus.a_d});
   end

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: cut the token list into rows of 8 and apply the end-of-stream rules.
   task automatic model();
      logic [15:0]  cur[$];
      logic [127:0] acc;
      exp_rows.delete();
      exp_err = 1'b0;
      exp_eos = 1'b0;
      foreach (sent[i]) begin
         if (!sent[i].e) begin
            cur.push_back(sent[i].d);
            if (cur.size() == 8) begin
               acc = '0;
               foreach (cur[k]) acc[16*k +: 16] = cur[k];
               exp_rows.push_back({8'h00, acc});
               cur.delete();
            end
         end else begin
            if (cur.size() != 0) begin
               exp_err = 1'b1;
`ifdef ILLM_ROW_GATHER_PAD_EN
               acc = '0;
               foreach (cur[k]) acc[16*k +: 16] = cur[k];
               exp_rows.push_back({8'h00, acc});
`endif
            end
            exp_rows.push_back({8'hFF, 128'h0});
            exp_eos = 1'b1;
            break;
         end
      end
   endtask

   task automatic send(input logic [15:0] d, input logic e, input int gap);
      bit ok = 1'b0;
      repeat (gap) begin
         bus.din_v = 1'b0;
         @(posedge clock); #1;
      end
      bus.din_v = 1'b1;
      bus.din_d = d;
      bus.din_e = e;
      for (int w = 0; w < 300 && !ok; w++) begin
         @(negedge clock);
         if (!bus.din_b) ok = 1'b1;
      end
      if (ok) begin
         @(posedge clock); #1;
      end
      check("accept_timeout", 136'(ok), 136'd1);
      bus.din_v = 1'b0;
   endtask

   task automatic play(input int gapmax);
      foreach (sent[i]) send(sent[i].d, sent[i].e, $urandom_range(0, gapmax));
   endtask

   task automatic do_reset();
      bus.din_v = 1'b0;
      bus.din_e = 1'b0;
      bus.din_d = 16'sd0;
      @(negedge clock); rst_n = 1'b0;
      @(negedge clock); rst_n = 1'b1;
      @(posedge clock); #1;
      gbase = got.size();
      sent.delete();
   endtask

   task automatic verify(input string tag);
      model();
      for (int w = 0; w < 4000 && (got.size() - gbase) < exp_rows.size(); w++) @(negedge clock);
      repeat (4) @(negedge clock);
      check({tag, "_rows"}, 136'(got.size() - gbase), 136'(exp_rows.size()));
      foreach (exp_rows[i]) begin
         if (gbase + i < got.size())
            check($sformatf("%s_row%0d", tag, i), got[gbase + i], exp_rows[i]);
      end
      check({tag, "_err"}, 136'(row_err), 136'(exp_err));
      check({tag, "_din_b"}, 136'(bus.din_b), 136'(exp_eos));
      check({tag, "_idle_v"}, 136'(bus.a_v), 136'd0);
      @(posedge clock); #1;
   endtask

   initial begin
      logic [127:0] row;
      bus.din_v = 1'b0;
      bus.din_e = 1'b0;
      bus.din_d = 16'sd0;

      // Reset values
      #12;
      check("rst_a_v", 136'(bus.a_v), 136'd0);
      check("rst_a_e", 136'(bus.a_e), 136'd0);
      check("rst_a_d", 136'(bus.a_d), 136'd0);
      check("rst_row_err", 136'(row_err), 136'd0);
      @(negedge clock); rst_n = 1'b1;
      @(negedge clock);
      check("rst_din_b", 136'(bus.din_b), 136'd0);
      @(posedge clock); #1;

      // One row 1..8, no stalls: valid the cycle after the 8th accept, busy one cycle
      do_reset();
      for (int i = 1; i <= 8; i++) sent.push_back({16'(i), 1'b0});
      row = '0;
      for (int i = 0; i < 8; i++) row[16*i +: 16] = 16'(i + 1);
      play(0);
      @(negedge clock);
      check("r030_v", 136'(bus.a_v), 136'hFF);
      check("r030_e", 136'(bus.a_e), 136'd0);
      check("r030_d", 136'(bus.a_d), 136'(row));
      check("r030_din_b", 136'(bus.din_b), 136'd1);
      @(negedge clock);
      check("r030_din_b_after", 136'(bus.din_b), 136'd0);
      check("r030_v_after", 136'(bus.a_v), 136'd0);
      @(posedge clock); #1;
      verify("r030");

      // Lane 3 stalled for 4 cycles: row held 5 cycles
      gbase = got.size();
      ab_force = 8'h08;
      play(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check($sformatf("r031_hold_v%0d", i), 136'(bus.a_v), 136'hFF);
         check($sformatf("r031_hold_d%0d", i), 136'(bus.a_d), 136'(row));
         check($sformatf("r031_din_b%0d", i), 136'(bus.din_b), 136'd1);
         @(posedge clock); #1;
         if (i == 3) ab_force = 8'h00;
      end
      verify("r031");

      // 1..16 with input gaps
      do_reset();
      for (int i = 1; i <= 16; i++) sent.push_back({16'(i), 1'b0});
      play(3);
      verify("r032");

      // Full row then end-of-stream
      do_reset();
      for (int i = 1; i <= 8; i++) sent.push_back({16'(i), 1'b0});
      sent.push_back({16'hBEEF, 1'b1});
      play(0);
      verify("r033");

      // Partial row 5,6,7 then end-of-stream
      do_reset();
      for (int i = 5; i <= 7; i++) sent.push_back({16'(i), 1'b0});
      sent.push_back({16'h1234, 1'b1});
      play(1);
      verify("r034");

      // Asynchronous reset while a row waits downstream
      do_reset();
      ab_force = 8'hFF;
      for (int i = 1; i <= 8; i++) sent.push_back({16'(i), 1'b0});
      play(0);
      @(negedge clock);
      check("r035_v_pre", 136'(bus.a_v), 136'hFF);
      #2 rst_n = 1'b0;
      #1;
      check("r035_v_async", 136'(bus.a_v), 136'd0);
      check("r035_d_async", 136'(bus.a_d), 136'd0);
      @(negedge clock); rst_n = 1'b1; ab_force = 8'h00;
      repeat (4) begin
         @(negedge clock);
         check("r035_idle_v", 136'(bus.a_v), 136'd0);
      end
      check("r035_nofire", 136'(got.size() - gbase), 136'd0);
      @(posedge clock); #1;
      sent.delete();
      for (int i = 9; i <= 16; i++) sent.push_back({16'(i), 1'b0});
      play(1);
      verify("r035");

      // Randomized episodes with random stalls
      bp_en = 1'b1;
      for (int ep = 0; ep < 24; ep++) begin
         int n;
         do_reset();
         n = $urandom_range(0, 27);
         for (int i = 0; i < n; i++) sent.push_back({16'($urandom_range(0, 65535)), 1'b0});
         if ($urandom_range(0, 3) != 0) sent.push_back({16'($urandom_range(0, 65535)), 1'b1});
         play(2);
         verify($sformatf("rnd%0d", ep));
      end
      bp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
